// File: rtl/eeprom_byte_disp.sv
// eeprom_byte_disp: converts one EEPROM read-back byte into two 4-bit digit codes (decimal or hex)
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   data_in, data_vld     byte and its one-cycle strobe (ignored while busy)
//   dec_mode              1 = decimal (double-dabble), 0 = hexadecimal; sampled with the strobe
//   busy, done            conversion in progress / one-cycle pulse when digits update
//   ovf                   decimal value above 99, digits saturated to 9,9
//   seg_data_h/_l         high/low digit codes for the segment decoders
module eeprom_byte_disp #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_vld,
  input  logic              dec_mode,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [3:0]        seg_data_h,
  output logic [3:0]        seg_data_l
);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t            state_q;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [11:0]       bcd_q, bcd_d, bcd_adj;
  logic [7:0]        raw_q;
  logic [3:0]        cnt_q, seg_h_q, seg_l_q;
  logic              mode_q, busy_q, done_q, ovf_q;
  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
  for (genvar i = 0; i < 3; i++) begin : g_adj
    assign bcd_adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
  end
  always_comb begin
    {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      raw_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      seg_h_q <= '0;
      seg_l_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (data_vld) begin
            bin_q   <= data_in;
            raw_q   <= 8'(data_in);
            bcd_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= dec_mode;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          bin_q   <= bin_d;
          bcd_q   <= bcd_d;
          cnt_q   <= cnt_q + 4'd1;
          state_q <= cnt_q == 4'(DATA_W - 1) ? DONE : CONV;
        end
        DONE: begin
          seg_h_q <= !mode_q ? raw_q[7:4] : |bcd_q[11:8] ? 4'd9 : bcd_q[7:4];
          seg_l_q <= !mode_q ? raw_q[3:0] : |bcd_q[11:8] ? 4'd9 : bcd_q[3:0];
          ovf_q   <= mode_q & |bcd_q[11:8];
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy       = busy_q;
  assign done       = done_q;
  assign ovf        = ovf_q;
  assign seg_data_h = seg_h_q;
  assign seg_data_l = seg_l_q;
endmodule

// File: tb/tb_eeprom_byte_disp.sv
// tb_eeprom_byte_disp: directed self-checking bench for eeprom_byte_disp
module tb_eeprom_byte_disp;
  logic       clk = 1'b0, rst_n = 1'b0, data_vld = 1'b0, dec_mode = 1'b0;
  logic [7:0] data_in = '0;
  logic       busy, done, ovf;
  logic [3:0] seg_data_h, seg_data_l;
  int         n_cmp = 0, n_fail = 0, lat, bc, dc;
  eeprom_byte_disp #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_vld(data_vld), .dec_mode(dec_mode),
    .busy(busy), .done(done), .ovf(ovf), .seg_data_h(seg_data_h), .seg_data_l(seg_data_l)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic strobe(input logic [7:0] d, input logic m);
    @(negedge clk);
    data_in = d; dec_mode = m; data_vld = 1'b1;
    @(negedge clk);
    data_vld = 1'b0;
  endtask
  task automatic wait_done(output int l, output int b);
    l = 0; b = 0;
    while (!done && l < 20) begin
      if (busy) b++;
      @(negedge clk);
      l++;
    end
  endtask
  task automatic run(input string tag, input logic [7:0] d, input logic m,
                     input logic [3:0] eh, input logic [3:0] el, input logic eo);
    strobe(d, m);
    wait_done(lat, bc);
    chk({tag, "_lat"}, lat, 9);
    chk({tag, "_busy_cycles"}, bc, 9);
    chk({tag, "_busy_in_done"}, busy, 0);
    chk({tag, "_h"}, seg_data_h, eh);
    chk({tag, "_l"}, seg_data_l, el);
    chk({tag, "_ovf"}, ovf, eo);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, done, 0);
  endtask
  initial begin
    #1;
    chk("rst_h", seg_data_h, 0);
    chk("rst_l", seg_data_l, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run("dec42", 8'd42, 1'b1, 4'd4, 4'd2, 1'b0);
    run("hex2a", 8'h2A, 1'b0, 4'h2, 4'hA, 1'b0);
    run("dec200", 8'd200, 1'b1, 4'd9, 4'd9, 1'b1);
    run("dec99", 8'd99, 1'b1, 4'd9, 4'd9, 1'b0);
    run("dec255", 8'd255, 1'b1, 4'd9, 4'd9, 1'b1);
    run("hexff", 8'hFF, 1'b0, 4'hF, 4'hF, 1'b0);
    // Strobe while busy is dropped
    strobe(8'd17, 1'b1);
    repeat (3) @(negedge clk);
    data_in = 8'd55; dec_mode = 1'b0; data_vld = 1'b1;
    @(negedge clk);
    data_vld = 1'b0;
    chk("drop_busy", busy, 1);
    wait_done(lat, bc);
    chk("drop_lat", lat, 5);
    chk("drop_h", seg_data_h, 1);
    chk("drop_l", seg_data_l, 7);
    chk("drop_ovf", ovf, 0);
    dc = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dc++;
    end
    chk("drop_single_done", dc, 0);
    chk("drop_idle", busy, 0);
    // Asynchronous reset mid-conversion
    strobe(8'd88, 1'b1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_h", seg_data_h, 0);
    chk("arst_l", seg_data_l, 0);
    chk("arst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dc = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dc++;
    end
    chk("arst_no_done", dc, 0);
    run("dec5", 8'd5, 1'b1, 4'd0, 4'd5, 1'b0);
    // Back-to-back: second strobe in the done cycle
    strobe(8'd0, 1'b1);
    wait_done(lat, bc);
    chk("b2b0_lat", lat, 9);
    chk("b2b0_h", seg_data_h, 0);
    chk("b2b0_l", seg_data_l, 0);
    data_in = 8'd10; dec_mode = 1'b1; data_vld = 1'b1;
    @(negedge clk);
    data_vld = 1'b0;
    chk("b2b1_accepted", busy, 1);
    chk("b2b1_done_low", done, 0);
    wait_done(lat, bc);
    chk("b2b1_lat", lat, 9);
    chk("b2b1_h", seg_data_h, 1);
    chk("b2b1_l", seg_data_l, 0);
    chk("b2b1_ovf", ovf, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
